imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a little-endian byte stream. The first 32-bit word is the word count.
// The words that follow are written to consecutive word addresses starting at
// BASE_ADDR. The core is held in reset until the whole image has been written.
module imem_loader #(
  parameter int          SIZE      = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     mem_we,
  output logic [31:0]              mem_a,
  output logic [31:0]              mem_wd,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     cpu_reset,
  output logic [$clog2(SIZE):0]    words_loaded
);

  localparam int WLW = $clog2(SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state_reg, state_next;
  logic [1:0]     bcnt_reg, bcnt_next;
  logic [23:0]    asm_reg;           // lanes 0..2; lane 3 is taken straight from rx_data
  logic [31:0]    len_reg;
  logic [31:0]    mem_a_reg, mem_wd_reg;
  logic [WLW-1:0] words_loaded_reg, wl_inc;
  logic           xfer, last_byte, restart;
  logic [31:0]    rx_word;

  // rx_ready depends only on the state, so the handshake never loops through the FSM.
  assign rx_ready  = (state_reg == S_LEN) || (state_reg == S_DATA);
  assign xfer      = rx_valid & rx_ready;
  assign last_byte = xfer & (bcnt_reg == 2'd3);
  assign rx_word   = {rx_data, asm_reg};
  assign wl_inc    = words_loaded_reg + WLW'(1);
  // A start is honoured only when no load is running.
  assign restart   = start & ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                              (state_reg == S_ERR));

  assign mem_a        = mem_a_reg;
  assign mem_wd       = mem_wd_reg;
  assign words_loaded = words_loaded_reg;

  // Next-state and per-state outputs.
  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_reset  = 1'b1;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        busy = 1'b1;
        if (last_byte) begin
          if (rx_word == 32'd0)             state_next = S_DONE;
          else if (rx_word > 32'(SIZE))     state_next = S_ERR;
          else                              state_next = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (last_byte) state_next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        state_next = (32'(wl_inc) == len_reg) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) state_next = S_LEN;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_next = S_LEN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Byte lane counter: restarts on every fresh entry into LEN or DATA.
  always_comb begin
    bcnt_next = bcnt_reg;
    if ((state_next != state_reg) && ((state_next == S_LEN) || (state_next == S_DATA)))
      bcnt_next = 2'd0;
    else if (xfer)
      bcnt_next = bcnt_reg + 2'd1;
  end

  // State and byte counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      bcnt_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  // One capture register per low byte lane; the top lane completes the word combinationally.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    // Latch byte gi of the current word when its handshake happens.
    always_ff @(posedge clk) begin
      if (reset)
        asm_reg[gi*8 +: 8] <= 8'd0;
      else if (xfer && (bcnt_reg == 2'(gi)))
        asm_reg[gi*8 +: 8] <= rx_data;
    end
  end

  // Declared word count of the current image.
  always_ff @(posedge clk) begin
    if (reset)
      len_reg <= 32'd0;
    else if (restart)
      len_reg <= 32'd0;
    else if ((state_reg == S_LEN) && last_byte)
      len_reg <= rx_word;
  end

  // Write address/data are registered on the edge that enters WRITE, so they are
  // valid in the same cycle as mem_we and hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_a_reg  <= 32'd0;
      mem_wd_reg <= 32'd0;
    end else if ((state_reg == S_DATA) && last_byte) begin
      mem_a_reg  <= BASE_ADDR + (32'(words_loaded_reg) << 2);
      mem_wd_reg <= rx_word;
    end
  end

  // Words written so far in this load; bumps as WRITE is left.
  always_ff @(posedge clk) begin
    if (reset)
      words_loaded_reg <= '0;
    else if (restart)
      words_loaded_reg <= '0;
    else if (state_reg == S_WRITE)
      words_loaded_reg <= wl_inc;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, gapped load, oversize length,
// zero length and reset in the middle of a word.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, busy, done, err, cpu_reset;
  logic [31:0] mem_a, mem_wd;
  logic [10:0] words_loaded;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int wr_cnt   = 0;

  imem_loader #(.SIZE(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .busy(busy), .done(done), .err(err), .cpu_reset(cpu_reset),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Count handshakes and memory writes as seen at each rising edge.
  always @(posedge clk) begin
    if (rx_valid && rx_ready) hs_cnt++;
    if (mem_we) wr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("rx_ready_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmode);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (gapmode != 0) ? ((k % 2) + int'($urandom_range(0, 2))) : 0);
  endtask

  // Send one data word and check the write lands in the cycle after its last byte.
  task automatic send_data(input logic [31:0] w, input logic [31:0] exp_a, input int gapmode);
    send_word(w, gapmode);
    @(negedge clk);
    $display("write expect a=0x%08h wd=0x%08h : we=%0b a=0x%08h wd=0x%08h",
             exp_a, w, mem_we, mem_a, mem_wd);
    chk("mem_we_latency", 32'(mem_we), 32'd1);
    chk("mem_a", mem_a, exp_a);
    chk("mem_wd", mem_wd, w);
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Two-word image: len=2, 0x00100513, 0x0000006F.
  task automatic load_image(input int gapmode);
    int hs0, wr0;
    hs0 = hs_cnt;
    wr0 = wr_cnt;
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("cpu_reset_loading", 32'(cpu_reset), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    send_word(32'd2, gapmode);
    send_data(32'h0010_0513, 32'h0, gapmode);
    send_data(32'h0000_006F, 32'h4, gapmode);
    @(negedge clk);
    rx_valid = 1'b0;
    $display("load gapmode=%0d: done=%0b cpu_reset=%0b words=%0d hs=%0d wr=%0d",
             gapmode, done, cpu_reset, words_loaded, hs_cnt - hs0, wr_cnt - wr0);
    chk("done", 32'(done), 32'd1);
    chk("cpu_reset_done", 32'(cpu_reset), 32'd0);
    chk("words_loaded", 32'(words_loaded), 32'd2);
    chk("handshakes", 32'(hs_cnt - hs0), 32'd12);
    chk("writes", 32'(wr_cnt - wr0), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, wr0;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state, then idle with no change.
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    wr0 = wr_cnt;
    repeat (10) @(negedge clk);
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("idle_rx_ready", 32'(rx_ready), 32'd0);
    chk("idle_writes", 32'(wr_cnt - wr0), 32'd0);

    // Back-to-back image.
    load_image(0);
    // Valid bytes offered in DONE must not be taken.
    hs0 = hs_cnt;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk("done_no_accept", 32'(hs_cnt - hs0), 32'd0);

    // Same image with gaps; start from DONE re-asserts cpu_reset.
    load_image(1);

    // Oversize length 1025.
    wr0 = wr_cnt;
    pulse_start();
    send_word(32'h0000_0401, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    $display("oversize len: err=%0b cpu_reset=%0b busy=%0b", err, cpu_reset, busy);
    chk("err_set", 32'(err), 32'd1);
    chk("err_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_rx_ready", 32'(rx_ready), 32'd0);
    chk("err_writes", 32'(wr_cnt - wr0), 32'd0);
    load_image(0);

    // Zero length goes straight to DONE.
    wr0 = wr_cnt;
    pulse_start();
    send_word(32'd0, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    $display("zero len: done=%0b cpu_reset=%0b words=%0d", done, cpu_reset, words_loaded);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("zero_words", 32'(words_loaded), 32'd0);
    chk("zero_writes", 32'(wr_cnt - wr0), 32'd0);

    // Reset after 2 of 4 data bytes, with start asserted alongside (reset wins).
    wr0 = wr_cnt;
    pulse_start();
    send_word(32'd1, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    $display("mid reset: busy=%0b cpu_reset=%0b rx_ready=%0b", busy, cpu_reset, rx_ready);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_writes", 32'(wr_cnt - wr0), 32'd0);
    load_image(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
